// File: rtl/updi_frame_tx.sv
// updi_frame_tx: one-entry buffered serializer that shifts 12-bit UART frames onto the UPDI line.
// Optional BREAK generation is built only when UPDI_TX_BREAK_EN is defined.
module updi_frame_tx #(
    parameter int unsigned GUARD_BITS = 1,
    parameter int unsigned BREAK_BITS = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_baud_div,
    input  logic [11:0] i_frame,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_break,
    output logic        o_tx,
    output logic        o_tx_oe,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_break_done
);

`ifdef UPDI_TX_BREAK_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GUARD, S_BREAK} state_t;
    localparam logic [4:0] BREAK_LAST = 5'(BREAK_BITS);
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GUARD} state_t;
`endif

    localparam logic [4:0] FRAME_LAST = 5'd11;
    localparam logic [4:0] GUARD_LAST = (GUARD_BITS == 0) ? 5'd0 : 5'(GUARD_BITS - 1);

    state_t      state_q, state_d;
    logic [11:0] buf_q, buf_d;
    logic [11:0] shreg_q, shreg_d;
    logic        buf_full_q, buf_full_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic        frame_done_q, frame_done_d;
    logic        accept;
    logic        bit_end;
    logic        unload;
    logic        go_next;

`ifdef UPDI_TX_BREAK_EN
    logic brk_pend_q, brk_pend_d;
    logic brk_hold_q, brk_hold_d;
    logic break_done_q, break_done_d;
    logic brk_go;
`endif

    // Reorders the frame so the shift register always sends its MSB: start, data LSB first, parity, stops.
    function automatic logic [11:0] serialize(input logic [11:0] f);
        return {f[11], f[3], f[4], f[5], f[6], f[7], f[8], f[9], f[10], f[2], f[1], f[0]};
    endfunction

    assign accept  = i_valid && o_ready;
    assign bit_end = (baud_q == 16'd0);

`ifdef UPDI_TX_BREAK_EN
    // A BREAK requested together with an accepted frame waits until that frame has been unloaded.
    assign brk_go  = brk_pend_q && !brk_hold_q;
    assign o_ready = !buf_full_q && !brk_pend_q;
`else
    assign o_ready = !buf_full_q;
    logic unused_ok;
    assign unused_ok = i_break | (BREAK_BITS == 0);
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        baud_d       = baud_q;
        div_d        = div_q;
        bit_d        = bit_q;
        frame_done_d = 1'b0;
        go_next      = 1'b0;
        unload       = 1'b0;
`ifdef UPDI_TX_BREAK_EN
        brk_pend_d   = brk_pend_q;
        brk_hold_d   = brk_hold_q;
        break_done_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: go_next = 1'b1;
            S_SHIFT: begin
                if (!bit_end) begin
                    baud_d = baud_q - 16'd1;
                end else if (bit_q == FRAME_LAST) begin
                    frame_done_d = 1'b1;
                    if (GUARD_BITS == 0) begin
                        go_next = 1'b1;
                    end else begin
                        state_d = S_GUARD;
                        bit_d   = 5'd0;
                        baud_d  = div_q;
                    end
                end else begin
                    shreg_d = {shreg_q[10:0], 1'b1};
                    bit_d   = bit_q + 5'd1;
                    baud_d  = div_q;
                end
            end
            S_GUARD: begin
                if (!bit_end) begin
                    baud_d = baud_q - 16'd1;
                end else if (bit_q == GUARD_LAST) begin
                    go_next = 1'b1;
                end else begin
                    bit_d  = bit_q + 5'd1;
                    baud_d = div_q;
                end
            end
`ifdef UPDI_TX_BREAK_EN
            S_BREAK: begin
                if (!bit_end) begin
                    baud_d = baud_q - 16'd1;
                end else if (bit_q == BREAK_LAST) begin
                    break_done_d = 1'b1;
                    brk_pend_d   = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    bit_d  = bit_q + 5'd1;
                    baud_d = div_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Shared decision point for IDLE and the end of a frame/guard: BREAK, then buffer, then idle.
        if (go_next) begin
`ifdef UPDI_TX_BREAK_EN
            if (brk_go) begin
                state_d = S_BREAK;
                baud_d  = i_baud_div;
                div_d   = i_baud_div;
                bit_d   = 5'd0;
            end else
`endif
            if (buf_full_q) begin
                state_d = S_SHIFT;
                shreg_d = serialize(buf_q);
                baud_d  = i_baud_div;
                div_d   = i_baud_div;
                bit_d   = 5'd0;
                unload  = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

`ifdef UPDI_TX_BREAK_EN
        if (unload) brk_hold_d = 1'b0;
        if (i_break && !brk_pend_q) begin
            brk_pend_d = 1'b1;
            brk_hold_d = accept;
        end
`endif

        buf_full_d = accept || (buf_full_q && !unload);
        buf_d      = accept ? i_frame : buf_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            buf_q        <= 12'h000;
            shreg_q      <= 12'hFFF;
            buf_full_q   <= 1'b0;
            baud_q       <= 16'd0;
            div_q        <= 16'd0;
            bit_q        <= 5'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            shreg_q      <= shreg_d;
            buf_full_q   <= buf_full_d;
            baud_q       <= baud_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef UPDI_TX_BREAK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            brk_pend_q   <= 1'b0;
            brk_hold_q   <= 1'b0;
            break_done_q <= 1'b0;
        end else begin
            brk_pend_q   <= brk_pend_d;
            brk_hold_q   <= brk_hold_d;
            break_done_q <= break_done_d;
        end
    end
    assign o_break_done = break_done_q;
`else
    assign o_break_done = 1'b0;
`endif

    // Line stays high whenever nothing is being driven low; the pad is released only in IDLE.
    always_comb begin
        o_tx    = 1'b1;
        o_tx_oe = 1'b1;
        case (state_q)
            S_IDLE:  o_tx_oe = 1'b0;
            S_SHIFT: o_tx = shreg_q[11];
`ifdef UPDI_TX_BREAK_EN
            S_BREAK: o_tx = (bit_q == BREAK_LAST);
`endif
            default: o_tx = 1'b1;
        endcase
    end

    assign o_busy       = (state_q != S_IDLE) || buf_full_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_updi_frame_tx.sv
// tb_updi_frame_tx: directed bench for updi_frame_tx with a cycle-timeline reference model.
// BREAK scenarios run when UPDI_TX_BREAK_EN is defined; otherwise i_break is checked to be ignored.
module tb_updi_frame_tx;

    localparam int GUARD = 1;
    localparam int BRK   = 24;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] baudDiv = 16'd3;
    logic [11:0] frameIn = 12'h000;
    logic        valid = 1'b0;
    logic        breakReq = 1'b0;
    logic        ready, tx, txOe, busy, frameDone, breakDone;

    int errors = 0;
    int checks = 0;
    int doneSeen = 0;
    int breakSeen = 0;

    updi_frame_tx #(.GUARD_BITS(GUARD), .BREAK_BITS(BRK)) dut (
        .i_clk(clock), .i_rst(reset), .i_baud_div(baudDiv), .i_frame(frameIn),
        .i_valid(valid), .o_ready(ready), .i_break(breakReq), .o_tx(tx),
        .o_tx_oe(txOe), .o_busy(busy), .o_frame_done(frameDone), .o_break_done(breakDone)
    );

    always #5 clock = ~clock;

    // Reference model: every transmitted item is expanded into a queue of per-cycle line values.
    typedef struct packed {logic tx; logic oe; logic fd; logic bd; logic clrb;} ent_t;
    ent_t sched[$];
    logic        mFull = 1'b0;
    logic [11:0] mBuf = 12'h000;
    logic        mBrk = 1'b0;
    logic        mAfter = 1'b0;
    int          serialOrder[12] = '{11, 3, 4, 5, 6, 7, 8, 9, 10, 2, 1, 0};

    function automatic ent_t mkEnt(input logic t, input logic o, input logic f, input logic b, input logic c);
        return {t, o, f, b, c};
    endfunction

    function automatic logic modelReady();
`ifdef UPDI_TX_BREAK_EN
        return !mFull && !mBrk;
`else
        return !mFull;
`endif
    endfunction

    task automatic genFrame(input logic [11:0] f, input logic [15:0] div);
        for (int j = 0; j < 12; j++)
            for (int c = 0; c <= int'(div); c++)
                sched.push_back(mkEnt(f[serialOrder[j]], 1'b1, 1'b0, 1'b0, 1'b0));
        for (int g = 0; g < GUARD; g++)
            for (int c = 0; c <= int'(div); c++)
                sched.push_back(mkEnt(1'b1, 1'b1, (g == 0 && c == 0), 1'b0, 1'b0));
    endtask

    task automatic genBreak(input logic [15:0] div);
        for (int b = 0; b < BRK; b++)
            for (int c = 0; c <= int'(div); c++)
                sched.push_back(mkEnt(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int c = 0; c <= int'(div); c++)
            sched.push_back(mkEnt(1'b1, 1'b1, 1'b0, 1'b0, (c == int'(div))));
        sched.push_back(mkEnt(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic modelStep();
        ent_t e;
        logic preFull, preReady, preBrk, preAfter;
        preFull  = mFull;
        preReady = modelReady();
        preBrk   = mBrk;
        preAfter = mAfter;
        if (sched.size() > 0) begin
            e = sched.pop_front();
            if (e.clrb) mBrk = 1'b0;
        end
        if (sched.size() == 0) begin
            if (preBrk && !preAfter) begin
                genBreak(baudDiv);
            end else if (preFull) begin
                genFrame(mBuf, baudDiv);
                mFull  = 1'b0;
                mAfter = 1'b0;
            end
        end
        if (valid && preReady) begin
            mBuf  = frameIn;
            mFull = 1'b1;
        end
`ifdef UPDI_TX_BREAK_EN
        if (breakReq && !preBrk) begin
            mBrk   = 1'b1;
            mAfter = valid && preReady;
        end
`endif
    endtask

    // Model advances on each rising edge and is cleared asynchronously by reset.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                sched.delete();
                mFull  = 1'b0;
                mBrk   = 1'b0;
                mAfter = 1'b0;
            end else begin
                modelStep();
            end
        end
    end

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        ent_t cur;
        cur = (sched.size() > 0) ? sched[0] : mkEnt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("o_tx", tx, cur.tx);
        checkBit("o_tx_oe", txOe, cur.oe);
        checkBit("o_frame_done", frameDone, cur.fd);
        checkBit("o_break_done", breakDone, cur.bd);
        checkBit("o_ready", ready, modelReady());
        checkBit("o_busy", busy, cur.oe || mFull);
    endtask

    // Single compare process: DUT outputs versus the model on every falling edge.
    initial forever begin
        @(negedge clock);
        checkOutput();
        if (frameDone) doneSeen++;
        if (breakDone) breakSeen++;
    end

    task automatic applyStimulus(input logic [11:0] f);
        int n;
        logic r;
        n = 0;
        valid   = 1'b1;
        frameIn = f;
        do begin
            @(negedge clock);
            r = ready;
            @(posedge clock);
            #1;
            n++;
        end while (!r && n < 2000);
        checkBit("handshake", r, 1'b1);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < 3000);
        checkBit("idle_reached", busy, 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] synchSeq;
        int d0, b0, cnt, n;
        synchSeq = 12'b0101_0101_0011;

        #2 reset = 1'b1;
        #1;
        checkBit("rst_tx", tx, 1'b1);
        checkBit("rst_oe", txOe, 1'b0);
        checkBit("rst_ready", ready, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_fd", frameDone, 1'b0);
        checkBit("rst_bd", breakDone, 1'b0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        waitCycles(2);

        $display("[TB] single SYNCH frame, baud_div=3");
        baudDiv = 16'd3;
        applyStimulus(12'h2AB);
        valid = 1'b0;
        @(posedge clock);
        for (int k = 0; k < 48; k++) begin
            @(negedge clock);
            checkBit("synch_bit", tx, synchSeq[11 - k / 4]);
            checkBit("synch_nodone", frameDone, 1'b0);
        end
        @(negedge clock);
        checkBit("synch_done_c49", frameDone, 1'b1);
        repeat (3) @(negedge clock);
        checkBit("guard_oe_held", txOe, 1'b1);
        @(negedge clock);
        checkBit("guard_oe_released", txOe, 1'b0);
        waitIdle();

        $display("[TB] back-to-back frames with a baud change for the second");
        d0 = doneSeen;
        applyStimulus(12'h2AB);
        applyStimulus(12'h549);
        valid = 1'b0;
        baudDiv = 16'd2;
        waitIdle();
        checkInt("b2b_done_pulses", doneSeen - d0, 2);

        $display("[TB] handshake stall, three frames, baud_div=0");
        baudDiv = 16'd0;
        d0 = doneSeen;
        applyStimulus(12'h0F3);
        applyStimulus(12'h3C7);
        applyStimulus(12'h155);
        valid = 1'b0;
        waitIdle();
        checkInt("stall_done_pulses", doneSeen - d0, 3);

`ifdef UPDI_TX_BREAK_EN
        $display("[TB] BREAK during a frame, baud_div=1");
        baudDiv = 16'd1;
        b0 = breakSeen;
        applyStimulus(12'h2AB);
        valid = 1'b0;
        waitCycles(6);
        breakReq = 1'b1;
        waitCycles(1);
        breakReq = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frameDone && n < 200);
        checkBit("brk_frame_done", frameDone, 1'b1);
        cnt = 0;
        while (tx && txOe && cnt < 200) begin cnt++; @(negedge clock); end
        checkInt("brk_guard_cycles", cnt, 2);
        cnt = 0;
        while (!tx && txOe && cnt < 200) begin cnt++; @(negedge clock); end
        checkInt("brk_low_cycles", cnt, 48);
        cnt = 0;
        while (tx && txOe && cnt < 200) begin cnt++; @(negedge clock); end
        checkInt("brk_high_cycles", cnt, 2);
        checkBit("brk_done_pulse", breakDone, 1'b1);
        checkBit("brk_ready_back", ready, 1'b1);
        waitIdle();
        checkInt("brk_done_count", breakSeen - b0, 1);

        $display("[TB] BREAK and frame requested together");
        d0 = doneSeen;
        b0 = breakSeen;
        valid    = 1'b1;
        frameIn  = 12'h549;
        breakReq = 1'b1;
        waitCycles(1);
        valid    = 1'b0;
        breakReq = 1'b0;
        waitIdle();
        checkInt("sim_frame_done", doneSeen - d0, 1);
        checkInt("sim_break_done", breakSeen - b0, 1);
`else
        $display("[TB] BREAK requests are ignored in this build");
        b0 = breakSeen;
        breakReq = 1'b1;
        waitCycles(1);
        breakReq = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checkBit("nobrk_oe", txOe, 1'b0);
            checkBit("nobrk_bd", breakDone, 1'b0);
        end
        @(posedge clock);
        #1;
        d0 = doneSeen;
        baudDiv  = 16'd1;
        valid    = 1'b1;
        frameIn  = 12'h549;
        breakReq = 1'b1;
        waitCycles(1);
        valid    = 1'b0;
        breakReq = 1'b0;
        waitIdle();
        checkInt("nobrk_frame_done", doneSeen - d0, 1);
        checkInt("nobrk_break_done", breakSeen - b0, 0);
`endif

        $display("[TB] reset during bit 5");
        baudDiv = 16'd3;
        applyStimulus(12'h2AB);
        valid = 1'b0;
        @(posedge clock);
        repeat (17) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkBit("midrst_tx", tx, 1'b1);
        checkBit("midrst_oe", txOe, 1'b0);
        checkBit("midrst_ready", ready, 1'b1);
        checkBit("midrst_busy", busy, 1'b0);
        d0 = doneSeen;
        @(negedge clock);
        #2 reset = 1'b0;
        waitCycles(60);
        checkInt("midrst_no_done", doneSeen - d0, 0);
        applyStimulus(12'h3C7);
        valid = 1'b0;
        waitIdle();
        checkInt("post_rst_done", doneSeen - d0, 1);

        waitCycles(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updi_frame_tx.md
# updi_frame_tx

Serializer stage directly downstream of the UPDI command generator. It accepts 12-bit pre-formatted UART frames over a valid/ready handshake and buffers one frame while another is shifting. Each frame goes out on the single-wire UPDI line at a programmable bit period, and the block inserts guard time between frames. It also drives the pad output-enable so the half-duplex line is released whenever the transmitter is idle.

## Interface
- `GUARD_BITS`, default 1: idle-high bit-times driven after every frame (0 = none).
- `BREAK_BITS`, default 24: low bit-times of a BREAK (only with `UPDI_TX_BREAK_EN`).
- `i_clk` input 1: clock, all state on rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_baud_div` input 16: bit period = `i_baud_div`+1 cycles; sampled when a frame or BREAK starts.
- `i_frame` input 12: `[11]` start (0), `[10:3]` data byte d[7:0], `[2]` parity, `[1:0]` stop bits (2'b11).
- `i_valid` input 1: `i_frame` valid.
- `o_ready` output 1: holding buffer empty and no BREAK pending.
- `i_break` input 1: one-cycle BREAK request.
- `o_tx` output 1: serial line value.
- `o_tx_oe` output 1: pad output enable.
- `o_busy` output 1: state != IDLE or buffer full.
- `o_frame_done` output 1: one-cycle pulse per completed frame.
- `o_break_done` output 1: one-cycle pulse per completed BREAK.

## Operation
- Reset values: `o_tx`=1, `o_tx_oe`=0, `o_ready`=1, `o_busy`=0, `o_frame_done`=0, `o_break_done`=0. Reset clears the buffer and BREAK request and aborts any frame mid-bit. The line is released immediately because `o_tx_oe` goes to 0.
- Buffer: one-entry holding register. A frame is accepted when `i_valid && o_ready` is high at a rising edge. `o_ready` is combinational on the buffer-full flag and the BREAK-pending flag.
- Bit order (UART, data LSB first): `i_frame[11]`, then `[3]`,`[4]`…`[10]`, then `[2]`, `[1]`, `[0]`. There are 12 bit-times per frame. The block transmits `i_frame` as given and does not check or recompute parity.
- Counters:
  - Baud counter is 16 bits. It loads `i_baud_div` at each bit start, counts down, and the bit ends when it reaches 0.
  - Bit counter is 5 bits and counts the bits of the current frame, guard period or BREAK.
- States:
  - IDLE (`o_tx`=1, `o_tx_oe`=0):
    - If a BREAK is pending, go to BREAK.
    - Otherwise, if the buffer is full, move the buffer into the shift register and go to SHIFT.
  - SHIFT (`o_tx_oe`=1): drives the current bit. After bit 12 ends, pulse `o_frame_done` and go to GUARD, or apply the GUARD exit rule at once when `GUARD_BITS`=0.
  - GUARD (`o_tx`=1, `o_tx_oe`=1): lasts `GUARD_BITS` bit-times. Exit rule, in priority order:
    1. BREAK pending: go to BREAK.
    2. Buffer full: go to SHIFT.
    3. Otherwise: go to IDLE.
  - BREAK (`o_tx`=0, `o_tx_oe`=1): lasts `BREAK_BITS` bit-times, followed by 1 bit-time high. Then pulse `o_break_done`, clear the pending flag and go to IDLE.
- Simultaneous events:
  - Buffer unload and new accept in the same cycle are legal; the buffer stays full.
  - `i_break` arriving together with `i_valid`: the frame is accepted and transmitted first, then the BREAK.
- `i_baud_div`=0 gives 1 cycle per bit.

## Timing
- Idle-to-line latency: frame accepted at edge E, SHIFT entered at edge E+1, so `o_tx`=0 and `o_tx_oe`=1 from E+1.
- Frame length: 12×(`i_baud_div`+1) cycles, plus guard of `GUARD_BITS`×(`i_baud_div`+1) cycles.
- `o_frame_done` is high for exactly the first cycle after bit 12 ends.
- Back-to-back frames: with the buffer full, the next start bit begins on the edge that ends the guard period, with no IDLE cycle in between.
- `o_ready` rises the cycle after the buffer unloads.

## Configuration
- `UPDI_TX_BREAK_EN` defined: the BREAK state, pending flag and `o_break_done` logic are built as described above.
- `UPDI_TX_BREAK_EN` undefined:
  - `i_break` is ignored and `o_break_done` is tied to 0.
  - The FSM has IDLE, SHIFT and GUARD only.
  - `o_ready` depends only on the buffer.

## Test plan
- Single frame: `i_baud_div`=3, `i_frame`=12'h2AB (SYNCH 0x55).
  - `o_tx` sequence 0,1,0,1,0,1,0,1,0,0,1,1, each bit held 4 cycles.
  - `o_frame_done` pulses at cycle 49 after start.
  - With `GUARD_BITS`=1, `o_tx_oe` falls 4 cycles after the pulse.
- Back-to-back: push 12'h2AB then 12'h549 (0xA9) while the first is shifting.
  - `o_ready` is 0 until the first frame unloads.
  - The second start bit follows the guard with no gap.
  - Exactly 2 `o_frame_done` pulses.
- Handshake stall: hold `i_valid`=1 with 3 frames while the line is busy.
  - Frames go out in order.
  - None are lost or duplicated.
- BREAK (macro on): `i_break` pulse during a frame with `i_baud_div`=1.
  - The frame completes, then the guard.
  - `o_tx`=0 for 48 cycles, then 2 cycles high.
  - `o_break_done` pulses and `o_ready` returns to 1.
- Reset mid-frame: assert `i_rst` during bit 5.
  - `o_tx`=1, `o_tx_oe`=0 and `o_ready`=1 immediately.
  - No `o_frame_done` pulse.
  - After release, a new frame transmits correctly.
- Macro off: `i_break` pulses have no effect and `o_break_done` stays 0.
